// File: rtl/rds_rx_sync.sv
// RDS block synchroniser: tracks block boundaries with the 10-bit syndrome and
// emits 16-bit information words plus complete error-free A/B/C/D groups.
module rds_rx_sync #(
  parameter int unsigned BAD_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_valid,
  input  logic        bit_in,
  output logic        blk_valid,
  output logic [15:0] blk_data,
  output logic [2:0]  blk_id,
  output logic        blk_err,
  output logic        synced,
  output logic        group_valid,
  output logic [63:0] group_data
);

  typedef enum logic [1:0] {SEARCH, PRESYNC, SYNC} state_t;

  localparam logic [9:0] OFS_A  = 10'h0FC;
  localparam logic [9:0] OFS_B  = 10'h198;
  localparam logic [9:0] OFS_C  = 10'h168;
  localparam logic [9:0] OFS_CP = 10'h350;
  localparam logic [9:0] OFS_D  = 10'h1B4;

  localparam logic [2:0] SLOT_A  = 3'd0;
  localparam logic [2:0] SLOT_B  = 3'd1;
  localparam logic [2:0] SLOT_C  = 3'd2;
  localparam logic [2:0] SLOT_CP = 3'd3;
  localparam logic [2:0] SLOT_D  = 3'd4;

  localparam logic [3:0] LIMIT = 4'(BAD_LIMIT);

  function automatic logic [9:0] syndrome(input logic [25:0] w);
    logic [10:0] t;
    logic [9:0]  r;
    r = '0;
    for (int i = 25; i >= 0; i--) begin
      t = {r, w[i]};
      if (t[10]) t = t ^ 11'h5B9;
      r = t[9:0];
    end
    return r;
  endfunction

  function automatic logic [9:0] offset_of(input logic [2:0] slot);
    case (slot)
      SLOT_A:  return OFS_A;
      SLOT_B:  return OFS_B;
      SLOT_C:  return OFS_C;
      SLOT_D:  return OFS_D;
      default: return OFS_CP;
    endcase
  endfunction

  function automatic logic [2:0] succ(input logic [2:0] slot);
    case (slot)
      SLOT_A:          return SLOT_B;
      SLOT_B:          return SLOT_C;
      SLOT_C, SLOT_CP: return SLOT_D;
      default:         return SLOT_A;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [24:0] shift_q, shift_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  slot_q, slot_d;
  logic [3:0]  bad_q, bad_d;
  logic        grp_ok_q, grp_ok_d;
  logic [47:0] grp_words_q, grp_words_d;
  logic        blk_valid_d, blk_err_d, group_valid_d, emit;
  logic [15:0] blk_data_d;
  logic [2:0]  blk_id_d;
  logic [63:0] group_data_d;

  // The 26-bit window is the 25 stored bits plus the bit arriving this cycle,
  // so a block is judged on its completing bit and emitted one cycle later.
  logic [25:0] window;
  logic [9:0]  syn;
  logic        cp_hit, exp_hit;

  assign window  = {shift_q, bit_in};
  assign syn     = syndrome(window);
  assign cp_hit  = (slot_q == SLOT_C) && (syn == OFS_CP);
  assign exp_hit = (syn == offset_of(slot_q)) || cp_hit;
  assign synced  = (state_q == SYNC);

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    slot_d        = slot_q;
    bad_d         = bad_q;
    grp_ok_d      = grp_ok_q;
    grp_words_d   = grp_words_q;
    blk_valid_d   = 1'b0;
    blk_data_d    = blk_data;
    blk_id_d      = blk_id;
    blk_err_d     = blk_err;
    group_valid_d = 1'b0;
    group_data_d  = group_data;
    emit          = 1'b0;

    if (bit_valid) begin
      shift_d = window[24:0];
      unique case (state_q)
        SEARCH: begin
          if (syn == OFS_A || syn == OFS_B || syn == OFS_C ||
              syn == OFS_CP || syn == OFS_D) begin
            state_d  = PRESYNC;
            cnt_d    = '0;
            bad_d    = '0;
            grp_ok_d = 1'b0;
            case (syn)
              OFS_A:         slot_d = SLOT_B;
              OFS_B:         slot_d = SLOT_C;
              OFS_C, OFS_CP: slot_d = SLOT_D;
              default:       slot_d = SLOT_A;
            endcase
          end
        end
        PRESYNC: begin
          if (cnt_q == 5'd25) begin
            cnt_d = '0;
            if (exp_hit) begin
              state_d = SYNC;
              emit    = 1'b1;
            end else begin
              state_d = SEARCH;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        SYNC: begin
          if (cnt_q == 5'd25) begin
            cnt_d = '0;
            emit  = 1'b1;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    // Slot tracking advances even on a bad block; only the partial group is lost.
    if (emit) begin
      blk_valid_d = 1'b1;
      blk_data_d  = window[25:10];
      blk_id_d    = cp_hit ? SLOT_CP : slot_q;
      blk_err_d   = !exp_hit;
      slot_d      = succ(slot_q);
      if (exp_hit) begin
        bad_d = '0;
        case (slot_q)
          SLOT_A: begin
            grp_ok_d           = 1'b1;
            grp_words_d[47:32] = window[25:10];
          end
          SLOT_B:  grp_words_d[31:16] = window[25:10];
          SLOT_C:  grp_words_d[15:0]  = window[25:10];
          default: begin
            grp_ok_d = 1'b0;
            if (grp_ok_q) begin
              group_valid_d = 1'b1;
              group_data_d  = {grp_words_q, window[25:10]};
            end
          end
        endcase
      end else begin
        grp_ok_d = 1'b0;
        if (bad_q + 4'd1 == LIMIT) begin
          state_d = SEARCH;
          bad_d   = '0;
        end else begin
          bad_d = bad_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SEARCH;
      shift_q     <= '0;
      cnt_q       <= '0;
      slot_q      <= '0;
      bad_q       <= '0;
      grp_ok_q    <= 1'b0;
      grp_words_q <= '0;
      blk_valid   <= 1'b0;
      blk_data    <= '0;
      blk_id      <= '0;
      blk_err     <= 1'b0;
      group_valid <= 1'b0;
      group_data  <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      bad_q       <= bad_d;
      grp_ok_q    <= grp_ok_d;
      grp_words_q <= grp_words_d;
      blk_valid   <= blk_valid_d;
      blk_data    <= blk_data_d;
      blk_id      <= blk_id_d;
      blk_err     <= blk_err_d;
      group_valid <= group_valid_d;
      group_data  <= group_data_d;
    end
  end

endmodule

// File: tb/tb_rds_rx_sync.sv
// Bench for rds_rx_sync: table-driven block stream with a pulse scoreboard,
// then hand-written loss-of-sync and mid-group reset sequences.
module tb_rds_rx_sync;

  logic        clk = 1'b0;
  logic        rst_n, bit_valid, bit_in;
  logic        blk_valid, blk_err, synced, group_valid;
  logic [15:0] blk_data;
  logic [2:0]  blk_id;
  logic [63:0] group_data;

  always #5 clk = ~clk;

  rds_rx_sync #(.BAD_LIMIT(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .blk_valid   (blk_valid),
    .blk_data    (blk_data),
    .blk_id      (blk_id),
    .blk_err     (blk_err),
    .synced      (synced),
    .group_valid (group_valid),
    .group_data  (group_data)
  );

  typedef struct {
    logic [15:0] data;
    logic [2:0]  ofs;
    logic [25:0] flip;
    logic        emit;
    logic [2:0]  id;
    logic        err;
    logic        gv;
    logic [63:0] gdata;
    logic        sync;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  id;
    logic        err;
    logic        gv;
    logic [63:0] gdata;
    logic        sync;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] ofs_val(input logic [2:0] s);
    case (s)
      3'd0:    return 10'h0FC;
      3'd1:    return 10'h198;
      3'd2:    return 10'h168;
      3'd3:    return 10'h350;
      default: return 10'h1B4;
    endcase
  endfunction

  // Long division with the generator aligned under each set high-order bit.
  function automatic logic [9:0] model_syn(input logic [25:0] w);
    logic [25:0] v;
    v = w;
    for (int i = 25; i >= 10; i--)
      if (v[i]) v = v ^ (26'h5B9 << (i - 10));
    return v[9:0];
  endfunction

  function automatic logic [25:0] make_block(input logic [15:0] data, input logic [2:0] ofs);
    return {data, model_syn({data, 10'h000}) ^ ofs_val(ofs)};
  endfunction

  task automatic expectBlk(input logic [15:0] data, input logic [2:0] id, input logic err,
                           input logic gv, input logic [63:0] gdata, input logic sync);
    exp_t e;
    e.data = data; e.id = id; e.err = err; e.gv = gv; e.gdata = gdata; e.sync = sync;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [25:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bit_in    = w[25 - i];
      bit_valid = 1'b1;
      @(posedge clk); #1;
      bit_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_blk_valid"},   64'(blk_valid),   64'h0);
    checkOutput({tag, "_blk_data"},    64'(blk_data),    64'h0);
    checkOutput({tag, "_blk_id"},      64'(blk_id),      64'h0);
    checkOutput({tag, "_blk_err"},     64'(blk_err),     64'h0);
    checkOutput({tag, "_synced"},      64'(synced),      64'h0);
    checkOutput({tag, "_group_valid"}, 64'(group_valid), 64'h0);
    checkOutput({tag, "_group_data"},  group_data,       64'h0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (blk_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_blk", 64'(blk_valid), 64'h0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("blk_data",    64'(blk_data),    64'(e.data));
          checkOutput("blk_id",      64'(blk_id),      64'(e.id));
          checkOutput("blk_err",     64'(blk_err),     64'(e.err));
          checkOutput("group_valid", 64'(group_valid), 64'(e.gv));
          checkOutput("blk_synced",  64'(synced),      64'(e.sync));
          if (e.gv) checkOutput("group_data", group_data, e.gdata);
        end
      end else if (group_valid) begin
        checkOutput("gv_without_blk", 64'(group_valid), 64'h0);
      end
    end
  endtask

  initial begin
    vec_t        vecs[20];
    logic [25:0] w;
    logic [2:0]  lslot[4];
    logic [9:0]  s;

    // data, offset, flip mask, emit, id, err, group_valid, group_data, synced
    vecs[0]  = '{16'h0000, 3'd0, 26'h0,  1'b0, 3'd0, 1'b0, 1'b0, 64'h0, 1'b0};
    vecs[1]  = '{16'h0000, 3'd1, 26'h0,  1'b1, 3'd1, 1'b0, 1'b0, 64'h0, 1'b1};
    vecs[2]  = '{16'h0000, 3'd2, 26'h0,  1'b1, 3'd2, 1'b0, 1'b0, 64'h0, 1'b1};
    vecs[3]  = '{16'h0000, 3'd4, 26'h0,  1'b1, 3'd4, 1'b0, 1'b0, 64'h0, 1'b1};
    vecs[4]  = '{16'h0000, 3'd0, 26'h0,  1'b1, 3'd0, 1'b0, 1'b0, 64'h0, 1'b1};
    vecs[5]  = '{16'h0000, 3'd1, 26'h0,  1'b1, 3'd1, 1'b0, 1'b0, 64'h0, 1'b1};
    vecs[6]  = '{16'h0000, 3'd2, 26'h0,  1'b1, 3'd2, 1'b0, 1'b0, 64'h0, 1'b1};
    vecs[7]  = '{16'h0000, 3'd4, 26'h0,  1'b1, 3'd4, 1'b0, 1'b1, 64'h0, 1'b1};
    vecs[8]  = '{16'h1234, 3'd0, 26'h0,  1'b1, 3'd0, 1'b0, 1'b0, 64'h0, 1'b1};
    vecs[9]  = '{16'h5678, 3'd1, 26'h0,  1'b1, 3'd1, 1'b0, 1'b0, 64'h0, 1'b1};
    vecs[10] = '{16'h9ABC, 3'd2, 26'h0,  1'b1, 3'd2, 1'b0, 1'b0, 64'h0, 1'b1};
    vecs[11] = '{16'hDEF0, 3'd4, 26'h0,  1'b1, 3'd4, 1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1};
    vecs[12] = '{16'h1111, 3'd0, 26'h0,  1'b1, 3'd0, 1'b0, 1'b0, 64'h0, 1'b1};
    vecs[13] = '{16'h2222, 3'd1, 26'h0,  1'b1, 3'd1, 1'b0, 1'b0, 64'h0, 1'b1};
    vecs[14] = '{16'h3333, 3'd2, 26'h20, 1'b1, 3'd2, 1'b1, 1'b0, 64'h0, 1'b1};
    vecs[15] = '{16'h4444, 3'd4, 26'h0,  1'b1, 3'd4, 1'b0, 1'b0, 64'h0, 1'b1};
    vecs[16] = '{16'hAAAA, 3'd0, 26'h0,  1'b1, 3'd0, 1'b0, 1'b0, 64'h0, 1'b1};
    vecs[17] = '{16'h5555, 3'd1, 26'h0,  1'b1, 3'd1, 1'b0, 1'b0, 64'h0, 1'b1};
    vecs[18] = '{16'h0F0F, 3'd3, 26'h0,  1'b1, 3'd3, 1'b0, 1'b0, 64'h0, 1'b1};
    vecs[19] = '{16'hF0F0, 3'd4, 26'h0,  1'b1, 3'd4, 1'b0, 1'b1, 64'hAAAA_5555_0F0F_F0F0, 1'b1};
    lslot = '{3'd0, 3'd1, 3'd2, 3'd4};

    rst_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    fork
      monitor();
    join_none
    checkIdle("reset");

    for (int i = 0; i < 20; i++) begin
      w = make_block(vecs[i].data, vecs[i].ofs) ^ vecs[i].flip;
      if (vecs[i].emit)
        expectBlk(vecs[i].data, vecs[i].id, vecs[i].err, vecs[i].gv, vecs[i].gdata, vecs[i].sync);
      applyStimulus(w, 26);
      checkOutput($sformatf("vec%0d_synced", i), 64'(synced), 64'(vecs[i].sync));
    end

    // Outputs hold across idle cycles with no bit_valid.
    repeat (10) @(posedge clk);
    #1;
    checkOutput("hold_blk_data",   64'(blk_data), 64'hF0F0);
    checkOutput("hold_blk_id",     64'(blk_id),   64'h4);
    checkOutput("hold_group_data", group_data,    64'hAAAA_5555_0F0F_F0F0);
    checkOutput("hold_synced",     64'(synced),   64'h1);

    // Eight blocks of random bits, each guaranteed not to hit its expected slot.
    for (int k = 0; k < 8; k++) begin
      w = 26'($urandom);
      s = model_syn(w);
      while (s == ofs_val(lslot[k % 4]) || (lslot[k % 4] == 3'd2 && s == 10'h350)) begin
        w = 26'($urandom);
        s = model_syn(w);
      end
      expectBlk(w[25:10], lslot[k % 4], 1'b1, 1'b0, 64'h0, (k < 7) ? 1'b1 : 1'b0);
      applyStimulus(w, 26);
    end
    checkOutput("lost_synced", 64'(synced), 64'h0);

    // Fresh acquisition, then reset in the middle of the D block.
    pulseReset();
    applyStimulus(make_block(16'h0000, 3'd0), 26);
    checkOutput("reacq1_after_A", 64'(synced), 64'h0);
    expectBlk(16'h00AB, 3'd1, 1'b0, 1'b0, 64'h0, 1'b1);
    applyStimulus(make_block(16'h00AB, 3'd1), 26);
    expectBlk(16'h00CD, 3'd2, 1'b0, 1'b0, 64'h0, 1'b1);
    applyStimulus(make_block(16'h00CD, 3'd2), 26);
    applyStimulus(make_block(16'h7777, 3'd4), 13);
    pulseReset();
    checkIdle("mid_group_reset");

    applyStimulus(make_block(16'h0000, 3'd0), 26);
    checkOutput("reacq2_after_A", 64'(synced), 64'h0);
    expectBlk(16'h0000, 3'd1, 1'b0, 1'b0, 64'h0, 1'b1);
    applyStimulus(make_block(16'h0000, 3'd1), 26);
    checkOutput("reacq2_after_B", 64'(synced), 64'h1);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("pending_blk", 64'(exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
